icmp_echo_tx: RTL and testbench

- Parametrised ICMP echo-reply generator for the Ethernet support core.
- Captures validated echo-request frames from the RX path into an NSLOT-deep ring of frame buffers.
- Rebuilds each stored request as an echo reply: swapped MAC/IP addresses, type 0, incrementally adjusted ICMP checksum.
- Streams the reply byte-wise to the head_tx priority arbiter. RX capture and TX playback run concurrently on separate memory ports.

---
 rtl/icmp_echo_tx.sv | 210 +++++++++++++++++++++
 tb/tb_icmp_echo_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icmp_echo_tx.sv
// icmp_echo_tx
//   Captures validated ICMP echo-request frames into a ring of frame
//   buffers and plays each one back as an echo reply. The reply has the
//   MAC and IP addresses swapped, type 0 and an adjusted checksum.
//   RX capture and TX playback use separate memory ports and run
//   concurrently.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   rx_data         RX frame byte (byte 0 = destination MAC, no CRC)
//   rx_write        rx_data valid this cycle
//   rx_done         end-of-frame strobe, after the last rx_write
//   rx_ok           sampled with rx_done: frame is a valid echo request
//   reply_req       a reply is ready; request to the TX arbiter
//   strobe          arbiter grant, held high for the whole transmit
//   tx_len          length of the head reply, valid while reply_req is high
//   data_out        reply byte stream, 2 cycles behind the byte counter
//   drop_cnt        wrapping count of discarded requests
module icmp_echo_tx #(
    parameter logic [47:0] MAC     = 48'h12555500012f,
    parameter int          AW      = 7,
    parameter int          SW      = 1,
    parameter int          MIN_LEN = 42
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_write,
    input  logic          rx_done,
    input  logic          rx_ok,
    output logic          reply_req,
    input  logic          strobe,
    output logic [AW:0]   tx_len,
    output logic [7:0]    data_out,
    output logic [7:0]    drop_cnt
);
    localparam int          NSLOT      = 1 << SW;
    localparam int          SLOT_BYTES = 1 << AW;
    localparam logic [AW:0] N_MAX      = '1;

    // Echo request (type 8) -> echo reply (type 0): ones-complement add 0x0800.
    function automatic logic [15:0] f_csum_adj(input logic [15:0] old);
        logic [16:0] s;
        s = {1'b0, old} + 17'h00800;
        return s[15:0] + {15'd0, s[16]};
    endfunction

    function automatic logic [AW:0] f_sat_inc(input logic [AW:0] n);
        return (n == N_MAX) ? n : n + 1'b1;
    endfunction

    // Stored byte index feeding output byte n (address swaps).
    function automatic logic [AW:0] f_src_idx(input logic [AW:0] n);
        int i;
        i = int'(n);
        if (i < 6)
            i = i + 6;
        else if (i >= 26 && i < 30)
            i = i + 4;
        else if (i >= 30 && i < 34)
            i = i - 4;
        return (AW+1)'(i);
    endfunction

    logic [7:0]      r_mem  [NSLOT*SLOT_BYTES];
    logic [AW:0]     r_len  [NSLOT];
    logic [15:0]     r_csum [NSLOT];

    logic [SW-1:0]   r_wptr, r_rptr;
    logic [SW:0]     r_count;
    logic [AW:0]     r_baddr;
    logic            r_busy, r_rej, r_ovf;
    logic [15:0]     r_csum_old;
    logic [7:0]      r_drop;
    logic            r_req;
    logic            r_strobe_d, r_tx_valid;
    logic [AW:0]     r_n;
    logic            r_act_p1;
    logic [AW:0]     r_n_p1;
    logic [SW+AW-1:0] r_raddr_p1;
    logic [7:0]      r_data_p2;

    logic            w_full, w_rej_now, w_wr_en, w_commit, w_release;
    logic [SW:0]     w_count_nxt;
    logic [AW:0]     w_src;
    logic [AW:0]     w_head_len;
    logic [15:0]     w_head_csum;
    logic [7:0]      w_rd_byte;
    logic [7:0]      w_sub;
    int              w_ni;

    assign w_full    = (r_count == (SW+1)'(NSLOT));
    // Slot availability is decided once, on the first byte of a frame.
    assign w_rej_now = r_busy ? r_rej : w_full;
    assign w_wr_en   = rx_write && !w_rej_now && !r_baddr[AW];
    assign w_commit  = rx_done && rx_ok && !r_rej && !r_ovf && (int'(r_baddr) >= MIN_LEN);
    // A grant that started on an empty ring streams zeros and frees nothing.
    assign w_release = r_strobe_d && !strobe && r_tx_valid;

    always_comb begin
        w_count_nxt = r_count;
        if (w_commit && !w_release)
            w_count_nxt = r_count + 1'b1;
        else if (!w_commit && w_release)
            w_count_nxt = r_count - 1'b1;
    end

    // RX control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baddr <= '0;
            r_busy  <= 1'b0;
            r_rej   <= 1'b0;
            r_ovf   <= 1'b0;
            r_drop  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (rx_write) begin
                r_busy <= 1'b1;
                r_rej  <= w_rej_now;
                if (r_baddr[AW])
                    r_ovf <= 1'b1;
                else
                    r_baddr <= r_baddr + 1'b1;
            end
            if (rx_done) begin
                r_baddr <= '0;
                r_busy  <= 1'b0;
                r_rej   <= 1'b0;
                r_ovf   <= 1'b0;
                if (w_commit)
                    r_wptr <= r_wptr + 1'b1;
                else
                    r_drop <= r_drop + 1'b1;
            end
            if (w_release)
                r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
        end
    end

    // Frame storage and per-slot metadata
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[{r_wptr, r_baddr[AW-1:0]}] <= rx_data;
        if (rx_write && int'(r_baddr) == 36)
            r_csum_old[15:8] <= rx_data;
        if (rx_write && int'(r_baddr) == 37)
            r_csum_old[7:0] <= rx_data;
        if (w_commit) begin
            r_len[r_wptr]  <= r_baddr;
            r_csum[r_wptr] <= f_csum_adj(r_csum_old);
        end
    end

    assign w_src       = f_src_idx(r_n);
    assign w_head_len  = r_len[r_rptr];
    assign w_head_csum = r_csum[r_rptr];
    assign w_rd_byte   = r_mem[r_raddr_p1];

    // Field substitution on the byte read for stage 1's counter value.
    always_comb begin
        w_ni  = int'(r_n_p1);
        w_sub = w_rd_byte;
        if (w_ni >= 6 && w_ni < 12)
            w_sub = MAC[8*(11-w_ni) +: 8];
        else if (w_ni == 34)
            w_sub = 8'h00;
        else if (w_ni == 36)
            w_sub = w_head_csum[15:8];
        else if (w_ni == 37)
            w_sub = w_head_csum[7:0];
        if (!r_act_p1 || !r_tx_valid || (r_n_p1 >= w_head_len))
            w_sub = 8'h00;
    end

    // TX: byte counter, stage 1 (read address), stage 2 (output byte)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe_d <= 1'b0;
            r_tx_valid <= 1'b0;
            r_n        <= '0;
            r_act_p1   <= 1'b0;
            r_n_p1     <= '0;
            r_raddr_p1 <= '0;
            r_data_p2  <= '0;
            r_req      <= 1'b0;
        end else begin
            r_strobe_d <= strobe;
            if (strobe && !r_strobe_d)
                r_tx_valid <= (r_count != '0);
            r_n <= strobe ? f_sat_inc(r_n) : '0;
            // ---- stage 1
            r_act_p1   <= strobe;
            r_n_p1     <= r_n;
            r_raddr_p1 <= {r_rptr, w_src[AW-1:0]};
            // ---- stage 2
            r_data_p2  <= w_sub;
            r_req      <= (w_count_nxt != '0) && !strobe;
        end
    end

    assign reply_req = r_req;
    assign tx_len    = (r_count != '0) ? w_head_len : '0;
    assign data_out  = r_data_p2;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_icmp_echo_tx.sv
// Testbench for icmp_echo_tx: directed scenarios plus randomized frames,
// with a queue-based scoreboard fed by a reference model of the reply.
module tb_icmp_echo_tx;
    localparam logic [47:0] MAC = 48'h12555500012f;

    logic       clk, rst;
    logic [7:0] rx_data;
    logic       rx_write, rx_done, rx_ok;
    logic       reply_req, strobe;
    logic [7:0] tx_len;
    logic [7:0] data_out, drop_cnt;

    icmp_echo_tx dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_write(rx_write),
        .rx_done(rx_done), .rx_ok(rx_ok), .reply_req(reply_req),
        .strobe(strobe), .tx_len(tx_len), .data_out(data_out),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] fstore [0:63][0:255];
    int         flen   [0:63];
    int         acc_q[$];          // ids of frames the DUT should hold, oldest first
    int         mdrop = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cap [0:511];
    int         cap_idx = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference reply: request with addresses swapped, type 0, checksum adjusted.
    function automatic logic [7:0] exp_byte(input int id, input int n);
        int old, nw;
        logic [47:0] mac;
        mac = MAC;
        if (n >= flen[id]) return 8'h00;
        if (n < 6)  return fstore[id][n+6];
        if (n < 12) return mac[47-8*(n-6) -: 8];
        if (n >= 26 && n < 30) return fstore[id][n+4];
        if (n >= 30 && n < 34) return fstore[id][n-4];
        if (n == 34) return 8'h00;
        if (n == 36 || n == 37) begin
            old = {16'd0, fstore[id][36], fstore[id][37]};
            nw  = old + 'h0800;
            if (nw > 'hFFFF) nw = nw - 'hFFFF;
            return (n == 36) ? nw[15:8] : nw[7:0];
        end
        return fstore[id][n];
    endfunction

    task automatic build(input int id, input int len);
        flen[id] = len;
        for (int i = 0; i < 256; i++) fstore[id][i] = 8'($urandom);
    endtask

    task automatic send(input int id, input bit ok);
        bit free, acc;
        free = acc_q.size() < 2;
        for (int i = 0; i < flen[id]; i++) begin
            rx_write = 1'b1; rx_data = fstore[id][i]; tick;
        end
        rx_write = 1'b0; rx_data = 8'h00; rx_done = 1'b1; rx_ok = ok; tick;
        rx_done = 1'b0; rx_ok = 1'b0;
        acc = ok && free && flen[id] >= 42 && flen[id] <= 128;
        if (acc) acc_q.push_back(id); else mdrop++;
        chk("drop_cnt", drop_cnt, mdrop & 255);
        chk("reply_req_rx", reply_req, int'(acc_q.size() != 0));
    endtask

    task automatic transmit(input int cyc);
        int id; bit have;
        have = acc_q.size() != 0;
        id = have ? acc_q[0] : 0;
        chk("reply_req_pre", reply_req, int'(have));
        if (have) chk("tx_len", tx_len, flen[id]);
        for (int n = 0; n < cyc; n++) exp_q.push_back(have ? exp_byte(id, n) : 8'h00);
        cap_idx = 0;
        strobe = 1'b1; tick;
        chk("reply_req_busy", reply_req, 0);
        for (int k = 1; k < cyc; k++) tick;
        strobe = 1'b0; tick;
        if (have) void'(acc_q.pop_front());
        chk("reply_req_post", reply_req, int'(acc_q.size() != 0));
        tick; tick; tick;
    endtask

    // Stream the head reply for t cycles while capturing frame id2 so that
    // its rx_done lands on the strobe-fall cycle.
    task automatic conc(input int t, input int id2);
        int id, f; bit free, acc;
        id = acc_q[0];
        f  = flen[id2];
        free = 1'b0;
        for (int n = 0; n < t; n++) exp_q.push_back(exp_byte(id, n));
        cap_idx = 0;
        for (int k = 0; k <= t; k++) begin
            strobe   = (k < t);
            rx_write = (k >= t - f) && (k < t);
            rx_data  = rx_write ? fstore[id2][k-(t-f)] : 8'h00;
            rx_done  = (k == t);
            rx_ok    = 1'b1;
            if (k == t - f) free = acc_q.size() < 2;
            tick;
            if (k == 0) chk("conc_req_busy", reply_req, 0);
        end
        rx_done = 1'b0; rx_ok = 1'b0; strobe = 1'b0;
        void'(acc_q.pop_front());
        acc = free && f >= 42 && f <= 128;
        if (acc) acc_q.push_back(id2); else mdrop++;
        chk("conc_req", reply_req, int'(acc_q.size() != 0));
        chk("conc_tx_len", tx_len, flen[id2]);
        chk("conc_drop", drop_cnt, mdrop & 255);
        tick; tick; tick;
    endtask

    // Scoreboard monitor: a byte is due two cycles after each strobe cycle.
    always @(negedge clk) begin : mon
        logic [1:0] sh;
        logic [7:0] e;
        if (rst) begin
            sh = 2'b00;
            exp_q.delete();
        end else begin
            if (sh[1]) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty: got %0h expected none", data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", data_out, e);
                    if (cap_idx < 512) cap[cap_idx] = data_out;
                    cap_idx++;
                end
            end else begin
                chk("data_idle", data_out, 0);
            end
            sh = {sh[0], strobe};
        end
    end

    initial begin
        int nid, len;
        rst = 1'b1; rx_data = 8'h00; rx_write = 1'b0; rx_done = 1'b0;
        rx_ok = 1'b0; strobe = 1'b0;
        tick; tick;
        chk("rst_reply_req", reply_req, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_tx_len", tx_len, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst = 1'b0; tick;

        // Grant with nothing stored: zeros, no release.
        transmit(8);

        // Directed 74-byte request.
        build(0, 74);
        fstore[0][6] = 8'h02; fstore[0][7] = 8'h00; fstore[0][8] = 8'h00;
        fstore[0][9] = 8'h00; fstore[0][10] = 8'h00; fstore[0][11] = 8'h01;
        fstore[0][26] = 8'hC0; fstore[0][27] = 8'hA8; fstore[0][28] = 8'h07; fstore[0][29] = 8'h09;
        fstore[0][30] = 8'hC0; fstore[0][31] = 8'hA8; fstore[0][32] = 8'h07; fstore[0][33] = 8'h02;
        fstore[0][36] = 8'hF7; fstore[0][37] = 8'hFF;
        send(0, 1'b1);
        chk("dir_tx_len", tx_len, 74);
        transmit(74);
        chk("dir_b0", cap[0], 8'h02);
        chk("dir_b5", cap[5], 8'h01);
        chk("dir_b6", cap[6], 8'h12);
        chk("dir_b11", cap[11], 8'h2f);
        chk("dir_b26", cap[26], 8'hC0);
        chk("dir_b29", cap[29], 8'h02);
        chk("dir_b33", cap[33], 8'h09);
        chk("dir_b34", cap[34], 8'h00);
        chk("dir_b36", cap[36], 8'hFF);
        chk("dir_b37", cap[37], 8'hFF);

        // Checksum end-around carry.
        build(1, 60); fstore[1][36] = 8'hF8; fstore[1][37] = 8'h00;
        send(1, 1'b1);
        transmit(60);
        chk("wrap_b36", cap[36], 8'h00);
        chk("wrap_b37", cap[37], 8'h01);

        // Full ring: third request dropped, replies in arrival order.
        build(2, 50 + int'($urandom_range(0, 50)));
        build(3, 50 + int'($urandom_range(0, 50)));
        build(4, 64);
        send(2, 1'b1); send(3, 1'b1); send(4, 1'b1);
        chk("full_drop", drop_cnt, 1);
        transmit(flen[2]);
        transmit(flen[3]);

        // Length and validity errors.
        build(5, 130); send(5, 1'b1);
        build(6, 30);  send(6, 1'b1);
        build(7, 74);  send(7, 1'b0);
        chk("err_drop", drop_cnt, 4);

        // Capture concurrent with playback, commit on the release cycle.
        build(8, 60); send(8, 1'b1);
        build(9, 50);
        conc(80, 9);
        transmit(50);

        // Grant held well past the frame and past counter saturation.
        build(10, 45); send(10, 1'b1);
        transmit(300);

        // Reset in the middle of a transmit.
        build(11, 60); send(11, 1'b1);
        for (int n = 0; n < 60; n++) exp_q.push_back(exp_byte(11, n));
        strobe = 1'b1;
        repeat (20) tick;
        #2;
        rst = 1'b1; strobe = 1'b0;
        #1;
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_req", reply_req, 0);
        chk("mid_rst_len", tx_len, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        acc_q.delete(); mdrop = 0;
        tick; tick;
        rst = 1'b0; tick; tick;
        chk("post_rst_req", reply_req, 0);
        build(12, 70); send(12, 1'b1);
        transmit(70);

        // Randomized frames and grant lengths.
        nid = 13;
        for (int it = 0; it < 12; it++) begin
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(20, 140))
                                               : int'($urandom_range(42, 128));
            build(nid, len);
            send(nid, $urandom_range(0, 4) != 0);
            nid++;
            if (acc_q.size() == 2 || $urandom_range(0, 1) == 1) begin
                len = (acc_q.size() != 0) ? flen[acc_q[0]] : 10;
                transmit(len - 4 + int'($urandom_range(0, 8)));
            end
        end
        while (acc_q.size() != 0) transmit(flen[acc_q[0]] + 2);

        tick; tick;
        chk("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
